// File: rtl/fpdiv_if.sv
// Handshake and operand/result bundle for the iterative single-precision divider.
interface fpdiv_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        dz;

    modport master (
        output start, a, b,
        input  busy, done, result, dz
    );

    modport slave (
        input  start, a, b,
        output busy, done, result, dz
    );
endinterface

// File: rtl/fpdiv.sv
// Iterative IEEE-754 binary32 divider: restoring radix-2 mantissa division,
// one quotient bit per cycle, then a single normalise/round-to-nearest-even cycle.
// Zero, infinity and NaN operands skip the iteration and finish in one cycle.
module fpdiv (
    input  logic   clk,
    input  logic   rst_n,
    fpdiv_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DIV, ROUND, SPEC} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        sign;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [24:0] rem;
    logic [23:0] dvs;
    logic [25:0] quo;
    logic        a_zero, a_inf, a_nan;
    logic        b_zero, b_inf, b_nan;

    logic        in_a_zero, in_a_inf, in_a_nan;
    logic        in_b_zero, in_b_inf, in_b_nan;
    logic        in_special;

    logic [24:0] tsub;
    logic [24:0] rem_next;
    logic        ge;

    logic [22:0] frac;
    logic [22:0] frac_rnd;
    logic        guard, sticky, round_up, carry;
    logic [9:0]  exp_q, exp_f;
    logic [31:0] rnd_result;

    logic [31:0] spec_result;
    logic        spec_dz;

    // Classify incoming operands; a zero exponent flushes denormals to zero.
    always_comb begin
        in_a_zero  = (bus.a[30:23] == 8'h00);
        in_a_inf   = (bus.a[30:23] == 8'hff) && (bus.a[22:0] == 23'd0);
        in_a_nan   = (bus.a[30:23] == 8'hff) && (bus.a[22:0] != 23'd0);
        in_b_zero  = (bus.b[30:23] == 8'h00);
        in_b_inf   = (bus.b[30:23] == 8'hff) && (bus.b[22:0] == 23'd0);
        in_b_nan   = (bus.b[30:23] == 8'hff) && (bus.b[22:0] != 23'd0);
        in_special = in_a_zero | in_a_inf | in_a_nan | in_b_zero | in_b_inf | in_b_nan;
    end

    // One restoring step: subtract the divisor if it fits, then shift the remainder.
    always_comb begin
        ge       = (rem >= {1'b0, dvs});
        tsub     = rem - {1'b0, dvs};
        rem_next = ge ? (tsub << 1) : (rem << 1);
    end

    // Normalise the 26-bit quotient, round to nearest-even, and clamp the exponent range.
    always_comb begin
        if (quo[25]) begin
            frac   = quo[24:2];
            guard  = quo[1];
            sticky = quo[0] | (|rem);
            exp_q  = {2'b00, ea} - {2'b00, eb} + 10'd127;
        end else begin
            frac   = quo[23:1];
            guard  = quo[0];
            sticky = |rem;
            exp_q  = {2'b00, ea} - {2'b00, eb} + 10'd126;
        end
        round_up          = guard & (sticky | frac[0]);
        {carry, frac_rnd} = {1'b0, frac} + {23'd0, round_up};
        exp_f             = exp_q + {9'd0, carry};
        if ($signed(exp_f) >= 10'sd255) begin
            rnd_result = {sign, 8'hff, 23'd0};
        end else if ($signed(exp_f) <= 10'sd0) begin
            rnd_result = {sign, 31'd0};
        end else begin
            rnd_result = {sign, exp_f[7:0], frac_rnd};
        end
    end

    // Special-operand result, first matching rule wins.
    always_comb begin
        spec_dz = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_result = 32'h7fc00000;
        end else if (a_inf) begin
            spec_result = {sign, 8'hff, 23'd0};
        end else if (b_zero) begin
            spec_result = {sign, 8'hff, 23'd0};
            spec_dz     = 1'b1;
        end else begin
            spec_result = {sign, 31'd0};
        end
    end

    // Control FSM and datapath registers; outputs change only on accept or completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 5'd0;
            sign       <= 1'b0;
            ea         <= 8'd0;
            eb         <= 8'd0;
            rem        <= 25'd0;
            dvs        <= 24'd0;
            quo        <= 26'd0;
            a_zero     <= 1'b0;
            a_inf      <= 1'b0;
            a_nan      <= 1'b0;
            b_zero     <= 1'b0;
            b_inf      <= 1'b0;
            b_nan      <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= 32'h00000000;
            bus.dz     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sign     <= bus.a[31] ^ bus.b[31];
                        ea       <= bus.a[30:23];
                        eb       <= bus.b[30:23];
                        rem      <= {2'b01, bus.a[22:0]};
                        dvs      <= {1'b1, bus.b[22:0]};
                        quo      <= 26'd0;
                        cnt      <= 5'd0;
                        a_zero   <= in_a_zero;
                        a_inf    <= in_a_inf;
                        a_nan    <= in_a_nan;
                        b_zero   <= in_b_zero;
                        b_inf    <= in_b_inf;
                        b_nan    <= in_b_nan;
                        bus.busy <= 1'b1;
                        state    <= in_special ? SPEC : DIV;
                    end
                end
                DIV: begin
                    rem <= rem_next;
                    quo <= {quo[24:0], ge};
                    if (cnt == 5'd25) begin
                        state <= ROUND;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ROUND: begin
                    bus.result <= rnd_result;
                    bus.dz     <= 1'b0;
                    bus.done   <= 1'b1;
                    bus.busy   <= 1'b0;
                    state      <= IDLE;
                end
                SPEC: begin
                    bus.result <= spec_result;
                    bus.dz     <= spec_dz;
                    bus.done   <= 1'b1;
                    bus.busy   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpdiv.sv
// Self-checking bench for fpdiv: directed cases, handshake corner cases and
// randomized operands compared against an arithmetic reference model.
module tb_fpdiv;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_mis;

    fpdiv_if bus ();

    fpdiv dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    function automatic bit refSpecial(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'h00) || (a[30:23] == 8'hff) ||
               (b[30:23] == 8'h00) || (b[30:23] == 8'hff);
    endfunction

    // Reference quotient {dz, result} from exact integer division and explicit RNE.
    function automatic logic [32:0] refDiv(input logic [31:0] a, input logic [31:0] b);
        logic   s;
        int     ea, eb, e, sh;
        longint num, mb, q, r, mant, low, half;
        bit     az, ai, an, bz, bi, bn, up;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        az = (ea == 0);
        ai = (ea == 255) && (a[22:0] == 23'd0);
        an = (ea == 255) && (a[22:0] != 23'd0);
        bz = (eb == 0);
        bi = (eb == 255) && (b[22:0] == 23'd0);
        bn = (eb == 255) && (b[22:0] != 23'd0);
        if (an || bn || (az && bz) || (ai && bi)) return {1'b0, 32'h7fc00000};
        if (ai) return {1'b0, s, 8'hff, 23'd0};
        if (bz) return {1'b1, s, 8'hff, 23'd0};
        if (az || bi) return {1'b0, s, 31'd0};
        num = longint'({1'b1, a[22:0]}) << 26;
        mb  = longint'({1'b1, b[22:0]});
        q   = num / mb;
        r   = num % mb;
        if (q >= (64'sd1 << 26)) begin
            sh = 3;
            e  = ea - eb + 127;
        end else begin
            sh = 2;
            e  = ea - eb + 126;
        end
        mant = q >> sh;
        low  = q & ((64'sd1 << sh) - 1);
        half = 64'sd1 << (sh - 1);
        up   = (low > half) || ((low == half) && ((r != 0) || ((mant % 2) == 1)));
        if (up) mant = mant + 1;
        if (mant == (64'sd1 << 24)) begin
            mant = 64'sd1 << 23;
            e    = e + 1;
        end
        if (e >= 255) return {1'b0, s, 8'hff, 23'd0};
        if (e <= 0) return {1'b0, s, 31'd0};
        return {1'b0, s, 8'(e), 23'(mant)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("[TB] FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Issue one operation from the current cycle and check the whole transaction;
    // a non-zero intrude pulses start with junk operands that many cycles after accept.
    task automatic applyStimulus(input logic [31:0] opa, input logic [31:0] opb, input int intrude);
        logic [32:0] exp;
        bit          spec;
        bit          busy_gap;
        int          lat;
        exp       = refDiv(opa, opb);
        spec      = refSpecial(opa, opb);
        bus.start = 1'b1;
        bus.a     = opa;
        bus.b     = opb;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        checkOutput("busy_after_accept", 32'(bus.busy), 32'd1);
        checkOutput("done_after_accept", 32'(bus.done), 32'd0);
        lat      = 0;
        busy_gap = 0;
        while (!bus.done && lat < 60) begin
            if (!bus.busy) busy_gap = 1;
            bus.start = (intrude != 0) && (lat == intrude);
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        checkOutput($sformatf("latency %08h/%08h", opa, opb), 32'(lat), spec ? 32'd1 : 32'd27);
        checkOutput("busy_held", 32'(busy_gap), 32'd0);
        checkOutput("busy_at_done", 32'(bus.busy), 32'd0);
        checkOutput($sformatf("result %08h/%08h", opa, opb), bus.result, exp[31:0]);
        checkOutput($sformatf("dz %08h/%08h", opa, opb), 32'(bus.dz), 32'(exp[32]));
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [31:0] held;
        n_vec     = 0;
        n_mis     = 0;
        clk       = 1'b0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;

        #12;
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_result", bus.result, 32'h00000000);
        checkOutput("reset_dz", 32'(bus.dz), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(32'h3f800000, 32'h3f800000, 0);
        checkOutput("one_over_one", bus.result, 32'h3f800000);
        applyStimulus(32'h40c00000, 32'h40000000, 0);
        checkOutput("six_over_two", bus.result, 32'h40400000);
        applyStimulus(32'h3f800000, 32'h40400000, 0);
        checkOutput("one_third", bus.result, 32'h3eaaaaab);
        applyStimulus(32'hbf800000, 32'h40400000, 0);
        checkOutput("neg_one_third", bus.result, 32'hbeaaaaab);

        held = bus.result;
        @(posedge clk); #1;
        checkOutput("done_pulse_width", 32'(bus.done), 32'd0);
        checkOutput("result_held", bus.result, held);

        applyStimulus(32'h3f800000, 32'h00000000, 0);
        checkOutput("pos_div_zero", bus.result, 32'h7f800000);
        checkOutput("pos_div_zero_dz", 32'(bus.dz), 32'd1);
        applyStimulus(32'hbf800000, 32'h00000000, 0);
        checkOutput("neg_div_zero", bus.result, 32'hff800000);
        applyStimulus(32'h00000000, 32'h00000000, 0);
        checkOutput("zero_over_zero", bus.result, 32'h7fc00000);
        checkOutput("zero_over_zero_dz", 32'(bus.dz), 32'd0);
        applyStimulus(32'h00000000, 32'h3fab851f, 0);
        checkOutput("zero_over_x", bus.result, 32'h00000000);
        applyStimulus(32'h7f800000, 32'h7f800000, 0);
        checkOutput("inf_over_inf", bus.result, 32'h7fc00000);

        applyStimulus(32'h7f000000, 32'h3e800000, 0);
        checkOutput("overflow", bus.result, 32'h7f800000);
        applyStimulus(32'h00800000, 32'h40000000, 0);
        checkOutput("underflow", bus.result, 32'h00000000);

        @(posedge clk); #1;
        applyStimulus(32'h40c00000, 32'h40000000, 5);
        checkOutput("start_ignored_mid_div", bus.result, 32'h40400000);

        applyStimulus(32'h3f800000, 32'h40400000, 0);
        applyStimulus(32'h40c00000, 32'h40000000, 0);
        checkOutput("back_to_back", bus.result, 32'h40400000);

        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a     = 32'h3f800000;
        bus.b     = 32'h40400000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
        checkOutput("midreset_done", 32'(bus.done), 32'd0);
        checkOutput("midreset_result", bus.result, 32'h00000000);
        checkOutput("midreset_dz", 32'(bus.dz), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        held = 32'd0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bus.done) held = 32'd1;
        end
        checkOutput("no_done_after_reset", held, 32'd0);
        applyStimulus(32'h40c00000, 32'h40000000, 0);
        checkOutput("after_reset_six_over_two", bus.result, 32'h40400000);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) != 0) begin
                ra[30:23] = 8'($urandom_range(64, 190));
                rb[30:23] = 8'($urandom_range(64, 190));
            end
            applyStimulus(ra, rb, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
